// File: rtl/vinstru_mch_if.sv
// -----------------------------------------------------------------------------
// vinstru_mch_if
//
// Purpose: bundles the BRAM write port driven by the vinstru_mch capture
//          engine so the generator and the buffer it fills share one handle.
//
// Parameters:
//   AW        BRAM word-address width (byte address is AW+2 bits wide)
//
// Signals:
//   bram_clk  BRAM port clock (the generator clock, passed through)
//   bram_rst  BRAM port reset (the generator reset, passed through)
//   bram_en   write strobe, one 32-bit word per cycle while high
//   bram_we   byte write enables, 4'hF whenever bram_en is high
//   bram_addr byte address {word_address, 2'b00}
//   bram_din  sample word {ch[7:0], frame[7:0], sample[15:0]}
//
// Modports:
//   master    the capture engine (drives everything)
//   slave     the BRAM / observer (samples everything)
// -----------------------------------------------------------------------------
interface vinstru_mch_if #(
  parameter int AW = 12
);

  logic            bram_clk;
  logic            bram_rst;
  logic            bram_en;
  logic [3:0]      bram_we;
  logic [AW+1:0]   bram_addr;
  logic [31:0]     bram_din;

  modport master (
    output bram_clk,
    output bram_rst,
    output bram_en,
    output bram_we,
    output bram_addr,
    output bram_din
  );

  modport slave (
    input bram_clk,
    input bram_rst,
    input bram_en,
    input bram_we,
    input bram_addr,
    input bram_din
  );

endinterface : vinstru_mch_if

// File: rtl/vinstru_mch.sv
// -----------------------------------------------------------------------------
// vinstru_mch
//
// Purpose: multi-channel virtual instrument. Generates NCH independent pulse
//          trains (optionally with pseudo-random noise) and writes them
//          channel-interleaved into a BRAM capture buffer. Supports
//          single-shot capture (stop after the buffer is full) and continuous
//          ring capture (wrap and keep going, done flags the first wrap).
//
// Optional feature macro:
//   VINSTRU_MCH_NOISE_EN  when defined, each channel carries a 16-bit Galois
//                         LFSR (mask 16'hB400) that advances on that channel's
//                         write cycle; noise term = lfsr & noise_amplitude.
//                         When undefined the noise term is 0 and
//                         noise_amplitude is ignored.
//
// Parameters:
//   NCH   channel count (1..16)
//   AW    BRAM word-address width, buffer depth 2^AW words
//   SEED  base LFSR seed, channel c uses SEED ^ (c+1)
//
// Ports:
//   clk              sole clock
//   reset            synchronous, active-high
//   enable           pulse term enable (0 forces the pulse term to 0)
//   run              level-sensitive capture request, starts on a rising edge
//   mode             0 single-shot, 1 continuous (latched at capture start)
//   pulse_period     NCH x 32, period in frames (0 behaves as 1)
//   pulse_width      NCH x 16, high time in frames
//   pulse_amplitude  NCH x 16, pulse level
//   noise_amplitude  NCH x 16, noise mask
//   done             capture complete / buffer wrapped at least once
//   busy             capture in progress
//   bram             BRAM write port (vinstru_mch_if master)
// -----------------------------------------------------------------------------
module vinstru_mch #(
  parameter int          NCH  = 4,
  parameter int          AW   = 12,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                run,
  input  logic                mode,
  input  logic [NCH*32-1:0]   pulse_period,
  input  logic [NCH*16-1:0]   pulse_width,
  input  logic [NCH*16-1:0]   pulse_amplitude,
  input  logic [NCH*16-1:0]   noise_amplitude,
  output logic                done,
  output logic                busy,
  vinstru_mch_if.master       bram
);

  localparam int              CW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]   CH_LAST   = CW'(NCH - 1);
  localparam logic [AW-1:0]   ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            run_q;
  logic            run_rise;
  logic            start;
  logic            writing;

  logic            mode_q;
  logic            wrapped_q;
  logic [AW-1:0]   waddr_q;
  logic [CW-1:0]   ch_q;
  logic [7:0]      frame_q;
  logic [31:0]     phase_q    [NCH];
  logic [31:0]     phase_last [NCH];

  logic [31:0]     period_q [NCH];
  logic [15:0]     width_q  [NCH];
  logic [15:0]     pamp_q   [NCH];

  logic [31:0]     cur_phase;
  logic [15:0]     pulse_term;
  logic [15:0]     noise_term;
  logic [16:0]     sum;
  logic [15:0]     sample;
  logic [31:0]     word;

  // ---------------------------------------------------------------------------
  // Pass-through clock/reset for the BRAM port
  // ---------------------------------------------------------------------------
  assign bram.bram_clk = clk;
  assign bram.bram_rst = reset;

  // ---------------------------------------------------------------------------
  // Run edge detection
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run;
    end
  end

  assign run_rise = run & ~run_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    writing = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          state_d = S_CAPTURE;
          start   = 1'b1;
        end
      end
      S_CAPTURE: begin
        // The word for the current slot is issued even on the abort cycle;
        // the registered outputs drop one cycle later.
        writing = 1'b1;
        if (!run) begin
          state_d = S_IDLE;
        end else if (!mode_q && (waddr_q == ADDR_LAST)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!run) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-channel parameter latch, loaded once per capture start so register
  // writes during a capture do not disturb it.
  // ---------------------------------------------------------------------------
  // NOTE: these holding registers have no reset: they are always loaded on
  // capture start before anything reads them, which keeps them free of reset
  // fan-out and lets them map onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int c = 0; c < NCH; c++) begin
        period_q[c] <= pulse_period[c*32 +: 32];
        width_q[c]  <= pulse_width[c*16 +: 16];
        pamp_q[c]   <= pulse_amplitude[c*16 +: 16];
      end
    end
  end

  // Last phase value per channel; a zero period behaves like a period of 1.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      phase_last[c] = (period_q[c] == 32'd0) ? 32'd0 : period_q[c] - 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture counters: word address, channel slot, frame, per-channel phase
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || start) begin
      waddr_q   <= '0;
      ch_q      <= '0;
      frame_q   <= '0;
      wrapped_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        phase_q[c] <= '0;
      end
    end else if (writing) begin
      // waddr wraps naturally at 2^AW; in single mode the FSM has already
      // left CAPTURE by then.
      waddr_q <= waddr_q + 1'b1;
      if (waddr_q == ADDR_LAST) begin
        wrapped_q <= 1'b1;
      end
      if (ch_q == CH_LAST) begin
        ch_q    <= '0;
        frame_q <= frame_q + 8'd1;
        for (int c = 0; c < NCH; c++) begin
          phase_q[c] <= (phase_q[c] >= phase_last[c]) ? 32'd0 : phase_q[c] + 32'd1;
        end
      end else begin
        ch_q <= ch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if (start) begin
      mode_q <= mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Noise source
  // ---------------------------------------------------------------------------
`ifdef VINSTRU_MCH_NOISE_EN
  logic [15:0] lfsr_q [NCH];
  logic [15:0] namp_q [NCH];

  always_ff @(posedge clk) begin
    if (start) begin
      for (int c = 0; c < NCH; c++) begin
        namp_q[c] <= noise_amplitude[c*16 +: 16];
      end
    end
  end

  // Galois LFSR, right-shifting, taps 16'hB400. Seeds are never zero so the
  // sequence never locks up.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      for (int c = 0; c < NCH; c++) begin
        lfsr_q[c] <= SEED ^ 16'(c + 1);
      end
    end else if (writing) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_q == CW'(c)) begin
          lfsr_q[c] <= lfsr_q[c][0] ? ((lfsr_q[c] >> 1) ^ 16'hB400) : (lfsr_q[c] >> 1);
        end
      end
    end
  end

  assign noise_term = lfsr_q[ch_q] & namp_q[ch_q];
`else
  logic unused_noise_amplitude;

  assign unused_noise_amplitude = ^noise_amplitude;
  assign noise_term             = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Sample datapath for the channel in the current slot
  // ---------------------------------------------------------------------------
  assign cur_phase  = phase_q[ch_q];
  // width >= period keeps the phase always below width: constant high.
  assign pulse_term = (enable && (cur_phase < {16'h0000, width_q[ch_q]})) ? pamp_q[ch_q] : 16'h0000;
  assign sum        = {1'b0, pulse_term} + {1'b0, noise_term};
  assign sample     = sum[16] ? 16'hFFFF : sum[15:0];
  assign word       = {8'(ch_q), frame_q, sample};

  // ---------------------------------------------------------------------------
  // Registered outputs, one cycle behind the FSM state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      done           <= 1'b0;
      busy           <= 1'b0;
      bram.bram_en   <= 1'b0;
      bram.bram_we   <= 4'h0;
      bram.bram_addr <= '0;
      bram.bram_din  <= 32'h0;
    end else begin
      unique case (state_q)
        S_CAPTURE: begin
          busy           <= 1'b1;
          bram.bram_en   <= 1'b1;
          bram.bram_we   <= 4'hF;
          bram.bram_addr <= {waddr_q, 2'b00};
          bram.bram_din  <= word;
          // Sticky in continuous mode from the first wrap onward; single
          // mode reports completion from DONE instead.
          done           <= mode_q & wrapped_q;
        end
        S_DONE: begin
          busy         <= 1'b0;
          bram.bram_en <= 1'b0;
          bram.bram_we <= 4'h0;
          done         <= 1'b1;
        end
        default: begin
          busy         <= 1'b0;
          bram.bram_en <= 1'b0;
          bram.bram_we <= 4'h0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule : vinstru_mch

// File: tb/tb_vinstru_mch.sv
// -----------------------------------------------------------------------------
// tb_vinstru_mch
//
// Purpose: directed self-checking bench for vinstru_mch with NCH=4, AW=6
//          (64-word buffer, 16 frames per pass). Covers reset values,
//          single-shot capture with mixed channel settings, parameter latching,
//          run held in DONE, enable=0, saturation, abort and restart,
//          continuous wrap and stop, and reset during a capture.
// -----------------------------------------------------------------------------
module tb_vinstru_mch;

  localparam int          NCH   = 4;
  localparam int          AW    = 6;
  localparam int          DEPTH = 1 << AW;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              run;
  logic              mode;
  logic [NCH*32-1:0] pulse_period;
  logic [NCH*16-1:0] pulse_width;
  logic [NCH*16-1:0] pulse_amplitude;
  logic [NCH*16-1:0] noise_amplitude;
  logic              done;
  logic              busy;

  vinstru_mch_if #(.AW(AW)) bram_if ();

  vinstru_mch #(
    .NCH  (NCH),
    .AW   (AW),
    .SEED (SEED)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .run             (run),
    .mode            (mode),
    .pulse_period    (pulse_period),
    .pulse_width     (pulse_width),
    .pulse_amplitude (pulse_amplitude),
    .noise_amplitude (noise_amplitude),
    .done            (done),
    .busy            (busy),
    .bram            (bram_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference copy of the channel settings
  logic [31:0] m_period [NCH];
  logic [15:0] m_width  [NCH];
  logic [15:0] m_amp    [NCH];
  logic [15:0] m_noise  [NCH];
  logic        m_enable;

  logic [31:0] words [DEPTH];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [31:0] per, input logic [15:0] wid,
                        input logic [15:0] amp, input logic [15:0] nz);
    pulse_period[c*32 +: 32]    = per;
    pulse_width[c*16 +: 16]     = wid;
    pulse_amplitude[c*16 +: 16] = amp;
    noise_amplitude[c*16 +: 16] = nz;
    m_period[c] = per;
    m_width[c]  = wid;
    m_amp[c]    = amp;
    m_noise[c]  = nz;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Expected word for channel c in frame f: phase is f mod period.
  function automatic logic [31:0] model_word(input int c, input int f, input logic [15:0] lf);
    longint      eff;
    longint      ph;
    logic [15:0] pulse;
    logic [15:0] noise;
    logic [16:0] s17;
    logic [15:0] s;
    eff   = (m_period[c] == 32'd0) ? 64'sd1 : longint'(m_period[c]);
    ph    = longint'(f) % eff;
    pulse = (m_enable && (ph < longint'(m_width[c]))) ? m_amp[c] : 16'h0000;
`ifdef VINSTRU_MCH_NOISE_EN
    noise = lf & m_noise[c];
`else
    noise = lf & 16'h0000;
`endif
    s17 = {1'b0, pulse} + {1'b0, noise};
    s   = s17[16] ? 16'hFFFF : s17[15:0];
    return {8'(c), 8'(f), s};
  endfunction

  // Full single-shot pass: raise run, collect DEPTH writes, compare each to
  // the model and the address sequence, then expect DONE. When poke is set,
  // ch0 amplitude is rewritten after the first write to show it is ignored.
  task automatic capture_single(input string tag, input bit poke);
    logic [15:0] lf [NCH];
    int          bad_addr;
    int          bad_data;
    logic [31:0] expw;
    for (int c = 0; c < NCH; c++) lf[c] = SEED ^ 16'(c + 1);
    bad_addr = 0;
    bad_data = 0;
    run = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      if (bram_if.bram_en !== 1'b1 || bram_if.bram_we !== 4'hF ||
          bram_if.bram_addr !== 8'(i * 4) || busy !== 1'b1) bad_addr++;
      words[i] = bram_if.bram_din;
      expw     = model_word(i % NCH, i / NCH, lf[i % NCH]);
      if (bram_if.bram_din !== expw) bad_data++;
      lf[i % NCH] = lfsr_step(lf[i % NCH]);
      if (poke && i == 0) pulse_amplitude[15:0] = 16'h7777;
    end
    check({tag, "_addr_seq_errors"}, 32'(bad_addr), 32'd0);
    check({tag, "_data_errors"}, 32'(bad_data), 32'd0);
    tick();
    check({tag, "_done_after_last"}, {29'd0, done, busy, bram_if.bram_en}, 32'b100);
  endtask

  task automatic drop_run_to_idle();
    run = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    int bad;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    run         = 1'b0;
    mode        = 1'b0;
    enable      = 1'b1;
    m_enable    = 1'b1;
    pulse_period    = '0;
    pulse_width     = '0;
    pulse_amplitude = '0;
    noise_amplitude = '0;

    // Channel mix: ch0 8/2 pulse, ch1 width==period (constant high),
    // ch2 period 0 width 3 (constant high), ch3 period 3 width 1.
    set_ch(0, 32'd8, 16'd2, 16'h1000, 16'h0000);
    set_ch(1, 32'd4, 16'd4, 16'h0200, 16'h0000);
    set_ch(2, 32'd0, 16'd3, 16'h0030, 16'h0000);
    set_ch(3, 32'd3, 16'd1, 16'h0004, 16'h0000);

    // ---------------- Reset values ----------------
    tick();
    tick();
    tick();
    check("reset_en_busy_done", {29'd0, bram_if.bram_en, busy, done}, 32'd0);
    check("reset_we", {28'd0, bram_if.bram_we}, 32'd0);
    check("reset_addr", {24'd0, bram_if.bram_addr}, 32'd0);
    check("reset_din", bram_if.bram_din, 32'd0);
    check("bram_rst_follows", {31'd0, bram_if.bram_rst}, 32'd1);
    reset = 1'b0;
    tick();
    check("bram_rst_release", {31'd0, bram_if.bram_rst}, 32'd0);

    // ---------------- Single-shot capture ----------------
    capture_single("single", 1'b1);
    check("single_w0",  words[0],  32'h0000_1000);
    check("single_w1",  words[1],  32'h0100_0200);
    check("single_w2",  words[2],  32'h0200_0030);
    check("single_w3",  words[3],  32'h0300_0004);
    check("single_a16", words[4],  32'h0001_1000);
    check("single_w7",  words[7],  32'h0301_0000);
    check("single_a32", words[8],  32'h0002_0000);
    check("single_w15", words[15], 32'h0303_0004);
    check("single_latched_amp", words[32], 32'h0008_1000);
    check("single_w60", words[60], 32'h000F_0000);
    check("single_w62", words[62], 32'h020F_0030);
    check("single_w63", words[63], 32'h030F_0004);
    set_ch(0, 32'd8, 16'd2, 16'h1000, 16'h0000);

    // run held high in DONE must not retrigger
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done !== 1'b1 || busy !== 1'b0 || bram_if.bram_en !== 1'b0) bad++;
    end
    check("done_hold_no_retrigger", 32'(bad), 32'd0);
    run = 1'b0;
    tick();
    check("done_leave_lag", {31'd0, done}, 32'd1);
    tick();
    check("done_cleared_in_idle", {31'd0, done}, 32'd0);

    // ---------------- enable=0 ----------------
    enable   = 1'b0;
    m_enable = 1'b0;
    capture_single("disabled", 1'b0);
    check("disabled_w0",  words[0],  32'h0000_0000);
    check("disabled_w63", words[63], 32'h030F_0000);
    drop_run_to_idle();
    enable   = 1'b1;
    m_enable = 1'b1;

    // ---------------- Saturation ----------------
    for (int c = 0; c < NCH; c++) set_ch(c, 32'd1, 16'd1, 16'hFFF0, 16'h00FF);
    capture_single("saturate", 1'b0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (words[i][15:0] < 16'hFFF0) bad++;
    check("saturate_floor", 32'(bad), 32'd0);
`ifdef VINSTRU_MCH_NOISE_EN
    // ch0 seed ACE0, noise E0: FFF0+E0 overflows; ch1 seed ACE3 likewise
    check("saturate_w0", words[0], 32'h0000_FFFF);
    check("saturate_w1", words[1], 32'h0100_FFFF);
`else
    check("saturate_w0", words[0], 32'h0000_FFF0);
    check("saturate_w1", words[1], 32'h0100_FFF0);
`endif
    drop_run_to_idle();

    // Restore the mixed channel set
    set_ch(0, 32'd8, 16'd2, 16'h1000, 16'h0000);
    set_ch(1, 32'd4, 16'd4, 16'h0200, 16'h0000);
    set_ch(2, 32'd0, 16'd3, 16'h0030, 16'h0000);
    set_ch(3, 32'd3, 16'd1, 16'h0004, 16'h0000);

    // ---------------- Abort and restart ----------------
    run = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("abort_10th_write_addr", {24'd0, bram_if.bram_addr}, 32'd36);
    run = 1'b0;
    tick();
    check("abort_sampled_edge_en", {31'd0, bram_if.bram_en}, 32'd1);
    tick();
    check("abort_en_busy_done", {29'd0, bram_if.bram_en, busy, done}, 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0 || bram_if.bram_en !== 1'b0) bad++;
    end
    check("abort_stays_idle", 32'(bad), 32'd0);
    run = 1'b1;
    tick();
    tick();
    check("restart_en", {31'd0, bram_if.bram_en}, 32'd1);
    check("restart_addr", {24'd0, bram_if.bram_addr}, 32'd0);
    check("restart_word", bram_if.bram_din, 32'h0000_1000);
    drop_run_to_idle();

    // ---------------- Continuous capture ----------------
    mode = 1'b1;
    run  = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      if (bram_if.bram_en !== 1'b1 || bram_if.bram_addr !== 8'(i * 4) || done !== 1'b0) bad++;
      if (i == 0) mode = 1'b0;
    end
    check("cont_first_pass", 32'(bad), 32'd0);
    tick();
    check("cont_wrap_addr", {24'd0, bram_if.bram_addr}, 32'd0);
    check("cont_wrap_en_done", {30'd0, bram_if.bram_en, done}, 32'b11);
    check("cont_wrap_word", bram_if.bram_din, 32'h0010_1000);
    tick();
    check("cont_next_addr", {24'd0, bram_if.bram_addr}, 32'd4);
    check("cont_next_word", bram_if.bram_din, 32'h0110_0200);
    run = 1'b0;
    tick();
    check("cont_stop_lag", {30'd0, bram_if.bram_en, done}, 32'b11);
    tick();
    check("cont_stop", {29'd0, bram_if.bram_en, done, busy}, 32'd0);
    tick();

    // ---------------- Reset during capture ----------------
    mode = 1'b0;
    run  = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    run   = 1'b0;
    tick();
    check("midreset_en_busy_done", {29'd0, bram_if.bram_en, busy, done}, 32'd0);
    check("midreset_we", {28'd0, bram_if.bram_we}, 32'd0);
    check("midreset_addr", {24'd0, bram_if.bram_addr}, 32'd0);
    check("midreset_din", bram_if.bram_din, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("post_reset_idle", {30'd0, bram_if.bram_en, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_vinstru_mch

// File: doc/vinstru_mch.md
# vinstru_mch

Multi-channel virtual instrument, the parametrised successor to the single-channel `vinstru` pulse/noise generator.
- Generates `NCH` independent pulse trains with optional pseudo-random noise.
- Writes them channel-interleaved into a BRAM capture buffer that software reads over PCIe.
- Sits on `axi_aclk` beside `mem_regfile`, which supplies all control fields.
- Adds single-shot or continuous (ring) capture and per-channel parameters.

## Interface
Parameters:
- `NCH`, 4, channel count (1–16).
- `AW`, 12, BRAM word-address width; buffer depth is 2^AW 32-bit words.
- `SEED`, 16'hACE1, base LFSR seed; channel c uses `SEED ^ (c+1)`, which is never zero.

Ports:
- `clk` in 1: sole clock (`axi_aclk`).
- `reset` in 1: synchronous, active-high.
- `enable` in 1: pulse term enable; 0 forces the pulse term to 0.
- `run` in 1: capture request, level-sensitive.
- `mode` in 1: 0 single-shot, 1 continuous.
- `pulse_period` in NCH×32: per-channel period, in frames.
- `pulse_width` in NCH×16: per-channel high time, in frames.
- `pulse_amplitude` in NCH×16: per-channel pulse level.
- `noise_amplitude` in NCH×16: per-channel noise mask.
- `done` out 1: capture complete (single) or buffer wrapped at least once (continuous).
- `busy` out 1: high in CAPTURE.
- `bram_clk` out 1: equals `clk`.
- `bram_rst` out 1: equals `reset`.
- `bram_en` out 1: write strobe.
- `bram_we` out 4: 4'hF when `bram_en` is high, else 0.
- `bram_addr` out AW+2: byte address `{waddr, 2'b00}`.
- `bram_din` out 32: sample word.

## Operation
- States are IDLE, CAPTURE and DONE. Reset enters IDLE.
- IDLE → CAPTURE on a rising edge of `run`, detected against a registered copy of `run`.
  - On entry, latch all per-channel parameters. Mid-run register writes are ignored.
  - On entry, clear `waddr`, the channel index `ch`, the frame counter `frame` and all phase counters, and reload the LFSRs.
- In CAPTURE, write one word per cycle for channel `ch`, then increment `ch`.
  - When `ch` wraps from NCH-1 to 0, increment `frame` and advance each channel's phase.
  - Phase wraps at `period-1`. `period==0` is treated as 1.
- Pulse term = `amplitude` if `enable && phase < width`, else 0. `width >= period` gives a constant-high pulse.
- Sample = pulse term + noise term, unsigned 17-bit sum, saturated to 16'hFFFF.
- Word = `{ch[7:0], frame[7:0], sample[15:0]}`.
- Address wrap:
  - Single mode: after the write to `waddr = 2^AW-1`, go to DONE.
  - Continuous mode: `waddr` wraps to 0, `done` sets sticky, and capture continues. `ch`/`frame` do not reset at the wrap.
- DONE holds `done=1` and `bram_en=0`. Go to IDLE when `run` is low.
- `run` low in CAPTURE aborts to IDLE.
  - Single mode: `done` stays 0.
  - Continuous mode: `done` clears.
- Leaving DONE or CAPTURE for IDLE clears `done`.
- `mode` is latched at CAPTURE entry.

## Timing
- Reset values: `done=0`, `busy=0`, `bram_en=0`, `bram_we=0`, `bram_addr=0`, `bram_din=0`, and state IDLE.
- All outputs are registered. If the `run` rise is sampled at edge k, `busy` and the first write (addr 0) appear after edge k+1.
- Writes are back-to-back, one per cycle, with no stalls.
- Single mode: last write after edge k+2^AW; `done=1` and `bram_en=0` after edge k+2^AW+1.
- Abort: `run` sampled low at edge j deasserts `bram_en` and `busy` after edge j+1.
- Reset mid-capture takes priority over everything. Outputs return to reset values after that edge.
- `run` held high in DONE does not retrigger; a fresh rising edge is required.

## Configuration
- `VINSTRU_MCH_NOISE_EN` defined:
  - One 16-bit Galois LFSR per channel, mask 16'hB400.
  - A channel's LFSR advances on that channel's write cycle.
  - Noise term = `lfsr & noise_amplitude`.
- Undefined: no LFSRs are instantiated, the noise term is 0, and `noise_amplitude` is ignored.

## Test plan
- Single mode, NCH=4, AW=6, noise off, ch0 period 8, width 2, amp 16'h1000:
  - Expect 64 writes at addresses 0,4,…,252.
  - addr 0 = 32'h0000_1000; addr 16 (frame 1, ch0) = 32'h0001_1000; addr 32 (frame 2, ch0) = 32'h0002_0000.
  - `done` rises one cycle after the last write.
- Saturation, with `VINSTRU_MCH_NOISE_EN`, amp 16'hFFF0, mask 16'h00FF: every sample is ≥16'hFFF0, and any sum over that is 16'hFFFF.
- Continuous mode, AW=6:
  - After 64 writes `bram_addr` returns to 0, `done`=1 and `bram_en` stays high.
  - `run`→0 drops `bram_en` and `done` one cycle later.
- Abort: `run`→0 at the 10th write. Expect `bram_en`=0 the next cycle, `done` never set, and the next `run` rise restarts at addr 0.
- Edge cases:
  - `period=0` and `width=3` gives a constant amplitude.
  - `enable=0` with noise off gives all samples 0.
  - Reset asserted mid-capture gives reset values next cycle.
